thermal_throttle_ctrl: RTL and testbench

//  Arbitrates the platform's thermal/reset throttle sources (CPU thermtrip, fan-alert IRQ,
//  PCH platform reset, BMC request) into a single prioritised state machine driving the
//  fan-gate and system-throttle outputs. All hold times count the free-running 1 ms tick.

---
 rtl/thermal_throttle_ctrl.sv | 135 +++++++++++++
 tb/tb_thermal_throttle_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/thermal_throttle_ctrl.sv
// thermal_throttle_ctrl: prioritised trip/throttle/fan FSM over the platform thermal and reset sources.
// Latency: outputs registered, 1 clk after the qualifying input or counter condition.
// Backpressure: none; level and pulse inputs are sampled every clk.
module thermal_throttle_ctrl #(
  parameter int ALERT_HOLD_MS   = 100,
  parameter int THROTTLE_MIN_MS = 20,
  parameter int PLTRST_DLY_MS   = 2,
  parameter int TRIP_FILT_CLKS  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cnt1ms_done,
  input  logic       irq_alert_n,
  input  logic       thermtrip_n,
  input  logic       pch_pltrst_n,
  input  logic       bmc_throttle_req,
  input  logic       trip_clear,
  output logic       fan_gate,
  output logic       throttle_sys,
  output logic       trip_latched,
  output logic [1:0] state
);

  localparam int AW = (ALERT_HOLD_MS   > 0) ? $clog2(ALERT_HOLD_MS + 1)   : 1;
  localparam int TW = (THROTTLE_MIN_MS > 0) ? $clog2(THROTTLE_MIN_MS + 1) : 1;
  localparam int PW = (PLTRST_DLY_MS   > 0) ? $clog2(PLTRST_DLY_MS + 1)   : 1;
  localparam int FW = (TRIP_FILT_CLKS  > 0) ? $clog2(TRIP_FILT_CLKS + 1)  : 1;

  localparam logic [AW-1:0] ALERT_LD = AW'(ALERT_HOLD_MS);
  localparam logic [TW-1:0] THR_LD   = TW'(THROTTLE_MIN_MS);
  localparam logic [PW-1:0] PL_LD    = PW'(PLTRST_DLY_MS);
  localparam logic [FW-1:0] FILT_MAX = FW'(TRIP_FILT_CLKS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FAN   = 2'd1,
    S_THROT = 2'd2,
    S_TRIP  = 2'd3
  } state_t;

  state_t        cur_st;
  state_t        nxt_st;
  logic [AW-1:0] alert_cnt;
  logic [TW-1:0] thr_cnt;
  logic [PW-1:0] pl_cnt;
  logic [FW-1:0] filter;
  logic          alert_q;
  logic          pltrst_q;
  logic          trip_det;
  logic          alert_ev;
  logic          pl_rise;
  logic          thr_req;
  logic          thr_reload;

  assign trip_det = (filter == FILT_MAX);
  assign alert_ev = alert_q & ~irq_alert_n;
  assign pl_rise  = ~pltrst_q & pch_pltrst_n;
  assign thr_req  = ~pch_pltrst_n | (pl_cnt != '0) | bmc_throttle_req;
  assign state    = cur_st;

  always_comb begin
    nxt_st     = cur_st;
    thr_reload = 1'b0;
    if (cur_st == S_TRIP) begin
      // A latched trip only releases once the source is gone and the filter has drained.
      if (trip_clear && thermtrip_n && !trip_det) nxt_st = S_IDLE;
    end else if (trip_det) begin
      nxt_st = S_TRIP;
    end else if (thr_req) begin
      nxt_st     = S_THROT;
      thr_reload = 1'b1;
    end else if (cur_st == S_THROT && thr_cnt != '0) begin
      nxt_st = S_THROT;
    end else if (alert_ev || alert_cnt != '0) begin
      nxt_st = S_FAN;
    end else begin
      nxt_st = S_IDLE;
    end
  end

  // Hold counters: reload beats a same-clk tick, decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alert_cnt <= '0;
      thr_cnt   <= THR_LD;
      pl_cnt    <= '0;
      filter    <= '0;
      alert_q   <= 1'b1;
      pltrst_q  <= 1'b1;
    end else begin
      alert_q  <= irq_alert_n;
      pltrst_q <= pch_pltrst_n;

      if (thermtrip_n) begin
        filter <= '0;
      end else if (filter != FILT_MAX) begin
        filter <= filter + 1'b1;
      end

      if (alert_ev) begin
        alert_cnt <= ALERT_LD;
      end else if (cnt1ms_done && alert_cnt != '0) begin
        alert_cnt <= alert_cnt - 1'b1;
      end

      if (thr_reload) begin
        thr_cnt <= THR_LD;
      end else if (cnt1ms_done && thr_cnt != '0) begin
        thr_cnt <= thr_cnt - 1'b1;
      end

      if (pl_rise) begin
        pl_cnt <= PL_LD;
      end else if (cnt1ms_done && pl_cnt != '0) begin
        pl_cnt <= pl_cnt - 1'b1;
      end
    end
  end

  // Outputs are decoded from the next state so they change together with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_st       <= S_THROT;
      fan_gate     <= 1'b1;
      throttle_sys <= 1'b1;
      trip_latched <= 1'b0;
    end else begin
      cur_st       <= nxt_st;
      fan_gate     <= (nxt_st != S_IDLE);
      throttle_sys <= (nxt_st == S_THROT) || (nxt_st == S_TRIP);
      trip_latched <= (nxt_st == S_TRIP);
    end
  end

endmodule

// File: tb/tb_thermal_throttle_ctrl.sv
// Bench for thermal_throttle_ctrl: directed scenarios plus random stimulus,
// checked every clk against a timestamp-based reference model.
module tb_thermal_throttle_ctrl;

  localparam int TP         = 4;
  localparam int ALERT_HOLD = 100;
  localparam int THR_MIN    = 20;
  localparam int PL_DLY     = 2;
  localparam int FILT       = 8;
  localparam int NEVER      = -1000000;

  logic       clk              = 1'b0;
  logic       rst_n            = 1'b0;
  logic       cnt1ms_done      = 1'b0;
  logic       irq_alert_n      = 1'b1;
  logic       thermtrip_n      = 1'b1;
  logic       pch_pltrst_n     = 1'b1;
  logic       bmc_throttle_req = 1'b0;
  logic       trip_clear       = 1'b0;
  logic       fan_gate;
  logic       throttle_sys;
  logic       trip_latched;
  logic [1:0] state;

  int n_pass   = 0;
  int n_checks = 0;
  int cyc      = 0;
  int ticks    = 0;

  // Reference model: holds are tracked as the tick count at which they were (re)armed.
  int m_state;
  int m_alert_t;
  int m_thr_t;
  int m_pl_t;
  int m_low_run;
  bit m_prev_alert;
  bit m_prev_pl;

  always #5 clk = ~clk;

  thermal_throttle_ctrl #(
    .ALERT_HOLD_MS  (ALERT_HOLD),
    .THROTTLE_MIN_MS(THR_MIN),
    .PLTRST_DLY_MS  (PL_DLY),
    .TRIP_FILT_CLKS (FILT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cnt1ms_done     (cnt1ms_done),
    .irq_alert_n     (irq_alert_n),
    .thermtrip_n     (thermtrip_n),
    .pch_pltrst_n    (pch_pltrst_n),
    .bmc_throttle_req(bmc_throttle_req),
    .trip_clear      (trip_clear),
    .fan_gate        (fan_gate),
    .throttle_sys    (throttle_sys),
    .trip_latched    (trip_latched),
    .state           (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s @cyc %0d: observed %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state      = 2;
    m_thr_t      = ticks;
    m_alert_t    = NEVER;
    m_pl_t       = NEVER;
    m_low_run    = 0;
    m_prev_alert = 1'b1;
    m_prev_pl    = 1'b1;
  endtask

  // One clk: drive the tick, predict from the rules, clock, then compare.
  task automatic step();
    bit trip_det, alert_ev, pl_rise, thr_req, thr_hold, alert_hold, reload;
    int nx;
    cnt1ms_done = ((cyc % TP) == TP - 1);
    trip_det    = (m_low_run >= FILT);
    alert_ev    = m_prev_alert && !irq_alert_n;
    pl_rise     = !m_prev_pl && pch_pltrst_n;
    thr_req     = !pch_pltrst_n || ((ticks - m_pl_t) < PL_DLY) || bmc_throttle_req;
    thr_hold    = (ticks - m_thr_t) < THR_MIN;
    alert_hold  = (ticks - m_alert_t) < ALERT_HOLD;
    reload      = 1'b0;
    if (m_state == 3)              nx = (trip_clear && thermtrip_n && !trip_det) ? 0 : 3;
    else if (trip_det)             nx = 3;
    else if (thr_req) begin        nx = 2; reload = 1'b1; end
    else if (m_state == 2 && thr_hold) nx = 2;
    else if (alert_ev || alert_hold)   nx = 1;
    else                           nx = 0;

    @(posedge clk);
    #1;
    cyc++;
    if (cnt1ms_done) ticks++;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (alert_ev) m_alert_t = ticks;
      if (pl_rise)  m_pl_t    = ticks;
      if (reload)   m_thr_t   = ticks;
      m_low_run    = thermtrip_n ? 0 : m_low_run + 1;
      m_prev_alert = irq_alert_n;
      m_prev_pl    = pch_pltrst_n;
      m_state      = nx;
    end
    check("state", state, m_state);
    check("fan_gate", fan_gate, m_state != 0);
    check("throttle_sys", throttle_sys, m_state >= 2);
    check("trip_latched", trip_latched, m_state == 3);
  endtask

  // After reset release the minimum throttle hold runs for exactly THR_MIN ticks.
  task automatic release_profile(input string tag);
    int t0;
    t0 = ticks;
    for (int i = 0; i < 30 * TP && throttle_sys; i++) step();
    check({tag, "_hold_ticks"}, ticks - t0, THR_MIN);
    check({tag, "_idle"}, state, 0);
    check({tag, "_fan_off"}, fan_gate, 0);
  endtask

  initial begin
    int t0, t_rel, t_a, low_seen, tt_left;
    model_reset();

    // Test 1: reset state and release profile
    repeat (3) step();
    check("rst_state", state, 2);
    check("rst_fan", fan_gate, 1);
    check("rst_throt", throttle_sys, 1);
    check("rst_trip", trip_latched, 0);
    rst_n = 1'b1;
    release_profile("t1");

    // Test 2: alert edge, second edge at tick 50 extends the hold
    irq_alert_n = 1'b0;
    step();
    check("t2_fan_on", fan_gate, 1);
    t0 = ticks;
    for (int i = 0; i < 60 * TP && (ticks - t0) < 50; i++) step();
    irq_alert_n = 1'b1;
    step();
    irq_alert_n = 1'b0;
    step();
    for (int i = 0; i < 200 * TP && fan_gate; i++) step();
    check("t2_hold_150", (ticks - t0 >= 149) && (ticks - t0 <= 151), 1);
    irq_alert_n = 1'b1;
    step();

    // Test 3: trip filter, clear ignored while low, clear after release
    thermtrip_n = 1'b0;
    repeat (7) step();
    thermtrip_n = 1'b1;
    repeat (2) step();
    check("t3_7clk_no_trip", trip_latched, 0);
    thermtrip_n = 1'b0;
    repeat (8) step();
    step();
    check("t3_trip", trip_latched, 1);
    check("t3_trip_throt", throttle_sys, 1);
    check("t3_trip_fan", fan_gate, 1);
    trip_clear = 1'b1;
    step();
    trip_clear = 1'b0;
    step();
    check("t3_clear_while_low", trip_latched, 1);
    thermtrip_n = 1'b1;
    repeat (2) step();
    trip_clear = 1'b1;
    step();
    trip_clear = 1'b0;
    check("t3_cleared", state, 0);
    step();

    // Test 4: platform reset; thr_cnt reloads while the request holds, incl. the 2-tick extension
    pch_pltrst_n = 1'b0;
    step();
    check("t4_enter", state, 2);
    t0 = ticks;
    for (int i = 0; i < 10 * TP && (ticks - t0) < 5; i++) step();
    pch_pltrst_n = 1'b1;
    t_rel = ticks;
    for (int i = 0; i < 60 * TP && throttle_sys; i++) step();
    check("t4_hold_after_release", ticks - t_rel, PL_DLY + THR_MIN);
    check("t4_idle", state, 0);

    // Test 5: alert during a BMC throttle is remembered
    bmc_throttle_req = 1'b1;
    step();
    t0 = ticks;
    low_seen = 0;
    for (int i = 0; i < 10 * TP && (ticks - t0) < 5; i++) step();
    irq_alert_n = 1'b0;
    step();
    t_a = ticks;
    irq_alert_n = 1'b1;
    for (int i = 0; i < 40 * TP && (ticks - t0) < 30; i++) begin
      step();
      if (!throttle_sys) low_seen++;
    end
    check("t5_throt_held", low_seen, 0);
    bmc_throttle_req = 1'b0;
    for (int i = 0; i < 40 * TP && state == 2; i++) step();
    check("t5_fan_after_throt", state, 1);
    for (int i = 0; i < 120 * TP && state == 1; i++) step();
    check("t5_idle", state, 0);
    check("t5_hold_100", (ticks - t_a >= 99) && (ticks - t_a <= 101), 1);

    // Test 6: asynchronous reset while tripped
    thermtrip_n = 1'b0;
    repeat (FILT + 1) step();
    check("t6_tripped", trip_latched, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_state", state, 2);
    check("t6_async_trip", trip_latched, 0);
    model_reset();
    thermtrip_n = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    release_profile("t6");

    // Random phase
    tt_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 25 == 0)  irq_alert_n      = ~irq_alert_n;
      if ($urandom % 400 == 0) pch_pltrst_n     = ~pch_pltrst_n;
      if ($urandom % 300 == 0) bmc_throttle_req = ~bmc_throttle_req;
      trip_clear = ($urandom % 16 == 0);
      if (tt_left > 0) begin
        thermtrip_n = 1'b0;
        tt_left--;
      end else begin
        thermtrip_n = 1'b1;
        if ($urandom % 80 == 0) tt_left = int'($urandom_range(1, 14));
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
